timer_ctrl: RTL
===============

# timer_ctrl

Front-panel control stage for the count-down timer, running on the 1 kHz system clock. It debounces three raw push-buttons and runs a stopped/running/alarm state machine. It drives the timer's `en`, `enc_sec` and `rst_counters` inputs. It monitors the timer's `seconds`/`mins`/`hrs` outputs to detect expiry and raise `alarm`.

## Interface
Parameters (1 cycle = 1 ms):
- DEBOUNCE_MS, 20: consecutive stable cycles needed before a raw button level is accepted.
- REPEAT_DELAY_MS, 500: hold time on btn_set before auto-repeat starts.
- REPEAT_RATE_MS, 100: auto-repeat period on btn_set.
- ALARM_MS, 5000: maximum alarm duration.

Ports:
- CLK  in  1  1 kHz clock.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_start  in  1  raw start/pause button, active-high, asynchronous.
- btn_set  in  1  raw "add one second" button, active-high, asynchronous.
- btn_clr  in  1  raw clear button, active-high, asynchronous.
- seconds  in  8  timer seconds value.
- mins  in  8  timer minutes value.
- hrs  in  8  timer hours value.
- en  out  1  timer run enable (level).
- enc_sec  out  1  one-cycle increment pulse to the timer.
- rst_counters  out  1  one-cycle clear pulse to the timer.
- alarm  out  1  expiry indication.
- state  out  2  IDLE=00, RUN=01, ALARM=10; 11 is never produced.

## Operation
Button conditioning, per button:
- Two-flop synchronizer, then a debounce counter.
- The debounced level changes only after the synchronized input differs from it for DEBOUNCE_MS consecutive cycles.
- Any shorter glitch restarts the counter.
- A press is a single-cycle strobe on the debounced 0->1 edge.

Zero flag: `tzero = (seconds==0 && mins==0 && hrs==0)`, evaluated combinationally from the inputs.

Simultaneous presses are resolved by priority: clr > start > set. Only the highest-priority press acts; the others are dropped.

State machine:
- IDLE (en=0):
  - clr press: rst_counters pulse.
  - start press with !tzero: go to RUN.
  - start press with tzero: ignored.
  - set press: enc_sec pulse.
  - set auto-repeat: while debounced btn_set stays high, one enc_sec pulse after REPEAT_DELAY_MS cycles from the press strobe, then one every REPEAT_RATE_MS cycles.
  - Release, or leaving IDLE, clears the repeat counter.
- RUN (en=1):
  - start press: go to IDLE (pause, timer value held).
  - clr press: rst_counters pulse and go to IDLE.
  - set presses and repeat: ignored.
  - tzero while in RUN: go to ALARM. This check has lower priority than clr and start in the same cycle.
- ALARM (en=0, alarm active):
  - A 13-bit or wider counter runs from 0.
  - Exit to IDLE when the counter reaches ALARM_MS-1, or on any button press (acknowledge).
  - The acknowledging press is consumed: no rst_counters and no enc_sec.
- Counters are sized by $clog2 of their parameter. No counter wraps; each clears on state exit or button release.

## Timing
- All outputs are registered.
- Reset values: en=0, enc_sec=0, rst_counters=0, alarm=0, state=00. Debounced levels=0, all counters=0.
- Latency from raw edge to press strobe: 2 (sync) + DEBOUNCE_MS cycles.
- Output pulses (enc_sec, rst_counters) appear the cycle after the strobe. The `en` and `state` change on that same cycle.
- enc_sec and rst_counters are exactly one cycle wide and are never asserted together.
- tzero seen in RUN at cycle N gives state=ALARM, en=0 and alarm=1 at N+1.
- The alarm duration is exactly ALARM_MS cycles when not acknowledged.
- Reset asserted mid-operation returns everything to reset values immediately. A button held through reset must be re-seen as stable high for DEBOUNCE_MS cycles and yields a press strobe after reset release.

## Configuration
- TIMER_CTRL_BLINK_EN defined: in ALARM, alarm toggles every 250 cycles, starting high on entry, giving a 2 Hz blink. It is forced low on exit.
- TIMER_CTRL_BLINK_EN undefined: alarm is steady high for the whole of ALARM.
- State timing is identical either way.

## Test plan
- Debounce: a 10-cycle high glitch on btn_set -> no enc_sec. A clean 30-cycle press -> exactly one enc_sec, 23 cycles after the rising edge.
- Auto-repeat: hold btn_set for 1000 cycles in IDLE -> 1 initial pulse, then pulses at +500, +600, …, +900 from the strobe (6 total).
- Run/pause: time 00:00:05, start press -> en=1, state=01. A second start press -> en=0, state=00, value held.
- Expiry: RUN with time reaching 00:00:00 -> next cycle state=10, en=0, alarm=1. With no press, alarm stays for 5000 cycles, then state=00.
- Priority and acknowledge: clr and start strobed in the same cycle in RUN -> rst_counters pulse, state=00, no re-entry to RUN. A set press during ALARM -> state=00 with no enc_sec.
- Reset mid-RUN: rst_n low for 3 cycles -> all outputs 0 asynchronously and state=00. Start press blocked while tzero=1.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: front-panel buttons, timer value and timer control lines of timer_ctrl.
// The slave side is the control stage; the master side is the panel/timer around it.
interface timer_ctrl_if;
  logic       btn_start;
  logic       btn_set;
  logic       btn_clr;
  logic [7:0] seconds;
  logic [7:0] mins;
  logic [7:0] hrs;
  logic       en;
  logic       enc_sec;
  logic       rst_counters;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output btn_start, btn_set, btn_clr, seconds, mins, hrs,
    input  en, enc_sec, rst_counters, alarm, state
  );

  modport slave (
    input  btn_start, btn_set, btn_clr, seconds, mins, hrs,
    output en, enc_sec, rst_counters, alarm, state
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: debounces the start/set/clear buttons and runs the IDLE/RUN/ALARM control FSM
// for the count-down timer (1 cycle = 1 ms).
// Optional feature macro: TIMER_CTRL_BLINK_EN -- alarm blinks at 2 Hz while in ALARM;
// when undefined alarm is steady high for the whole of ALARM.
module timer_ctrl #(
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned ALARM_MS        = 5000
) (
  input logic         CLK,
  input logic         rst_n,
  timer_ctrl_if.slave bus
);
  localparam int unsigned DbW  = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int unsigned RepW = (REPEAT_DELAY_MS > 1) ? $clog2(REPEAT_DELAY_MS) : 1;
  localparam int unsigned AlmW = ($clog2(ALARM_MS) > 13) ? $clog2(ALARM_MS) : 13;

  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_MS - 1);
  localparam logic [RepW-1:0] RepLast   = RepW'(REPEAT_DELAY_MS - 1);
  localparam logic [RepW-1:0] RepReload = RepW'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
  localparam logic [AlmW-1:0] AlmLast   = AlmW'(ALARM_MS - 1);

`ifdef TIMER_CTRL_BLINK_EN
  localparam int unsigned     BlinkMs   = 250;
  localparam int unsigned     BlinkW    = $clog2(BlinkMs);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BlinkMs - 1);
  logic [BlinkW-1:0] blink_cnt_q;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StAlarm = 2'b10
  } state_e;

  // Button index: 0 = clr, 1 = start, 2 = set (also the priority order).
  logic [2:0]          raw;
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          deb_q, deb_d;
  logic [2:0]          press_q;
  logic [2:0][DbW-1:0] db_cnt_q, db_cnt_d;

  state_e              state_q;
  logic                en_q, enc_sec_q, rst_cnt_q, alarm_q;
  logic [AlmW-1:0]     alm_cnt_q;
  logic                rep_act_q;
  logic [RepW-1:0]     rep_cnt_q;
  logic                tzero;
  logic                rep_tick;

  assign raw   = {bus.btn_set, bus.btn_start, bus.btn_clr};
  assign tzero = (bus.seconds == 8'd0) && (bus.mins == 8'd0) && (bus.hrs == 8'd0);

  // Auto-repeat fires only while armed by an IDLE set press and the button is still held.
  assign rep_tick = (state_q == StIdle) && rep_act_q && deb_q[2] && (rep_cnt_q == RepLast);

  // Two-flop synchronizers for the asynchronous raw buttons.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: adopt the synchronized level after DEBOUNCE_MS differing cycles.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced levels, counters and the single-cycle press strobe on each 0->1 edge.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      deb_q    <= '0;
      db_cnt_q <= '0;
      press_q  <= '0;
    end else begin
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= deb_d & ~deb_q;
    end
  end

  // Control FSM with registered outputs; presses resolved clr > start > set.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      en_q        <= 1'b0;
      enc_sec_q   <= 1'b0;
      rst_cnt_q   <= 1'b0;
      alarm_q     <= 1'b0;
      alm_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_cnt_q   <= '0;
`ifdef TIMER_CTRL_BLINK_EN
      blink_cnt_q <= '0;
`endif
    end else begin
      enc_sec_q <= 1'b0;
      rst_cnt_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!deb_q[2]) begin
            rep_act_q <= 1'b0;
            rep_cnt_q <= '0;
          end else if (rep_act_q) begin
            rep_cnt_q <= rep_tick ? RepReload : rep_cnt_q + 1'b1;
          end
          if (press_q[0]) begin
            rst_cnt_q <= 1'b1;
          end else if (press_q[1]) begin
            // start with a zero timer is swallowed, and still outranks set
            if (!tzero) begin
              state_q   <= StRun;
              en_q      <= 1'b1;
              rep_act_q <= 1'b0;
              rep_cnt_q <= '0;
            end
          end else if (press_q[2]) begin
            enc_sec_q <= 1'b1;
            rep_act_q <= 1'b1;
            rep_cnt_q <= '0;
          end else if (rep_tick) begin
            enc_sec_q <= 1'b1;
          end
        end
        StRun: begin
          rep_act_q <= 1'b0;
          rep_cnt_q <= '0;
          if (press_q[0]) begin
            rst_cnt_q <= 1'b1;
            state_q   <= StIdle;
            en_q      <= 1'b0;
          end else if (press_q[1]) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
          end else if (tzero) begin
            state_q     <= StAlarm;
            en_q        <= 1'b0;
            alarm_q     <= 1'b1;
            alm_cnt_q   <= '0;
`ifdef TIMER_CTRL_BLINK_EN
            blink_cnt_q <= '0;
`endif
          end
        end
        StAlarm: begin
          rep_act_q <= 1'b0;
          rep_cnt_q <= '0;
          // any press only acknowledges; it produces no pulse
          if ((|press_q) || (alm_cnt_q == AlmLast)) begin
            state_q     <= StIdle;
            alarm_q     <= 1'b0;
            alm_cnt_q   <= '0;
`ifdef TIMER_CTRL_BLINK_EN
            blink_cnt_q <= '0;
`endif
          end else begin
            alm_cnt_q <= alm_cnt_q + 1'b1;
`ifdef TIMER_CTRL_BLINK_EN
            if (blink_cnt_q == BlinkLast) begin
              blink_cnt_q <= '0;
              alarm_q     <= ~alarm_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en           = en_q;
  assign bus.enc_sec      = enc_sec_q;
  assign bus.rst_counters = rst_cnt_q;
  assign bus.alarm        = alarm_q;
  assign bus.state        = state_q;

endmodule
